// File: rtl/fixed_softplus_backward_pkg.sv
// Shared constants, segment codes and breakpoint helpers for the softplus
// backward pass (sigmoid via the PLAN piecewise-linear approximation).
package fixed_softplus_backward_pkg;

  // Sigmoid values are unsigned Q1.15, so 1.0 is 32768
  localparam int unsigned SIG_FRAC = 15;
  localparam int unsigned SIG_ONE  = 32768;
  localparam int unsigned OFF0     = 16384;
  localparam int unsigned OFF1     = 20480;
  localparam int unsigned OFF2     = 27648;
  localparam int unsigned RND_HALF = 16384;

  // Slopes 1/4, 1/8 and 1/32 expressed as right shifts
  localparam int unsigned SH0 = 2;
  localparam int unsigned SH1 = 3;
  localparam int unsigned SH2 = 5;

  typedef enum logic [1:0] {
    SEG0    = 2'd0,
    SEG1    = 2'd1,
    SEG2    = 2'd2,
    SEG_SAT = 2'd3
  } seg_e;

  // Breakpoints 1.0, 2.375 and 5.0 in a format with frac fractional bits
  function automatic int unsigned bp1(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  function automatic int unsigned bp2(input int unsigned frac);
    return 32'd19 << (frac - 32'd3);
  endfunction

  function automatic int unsigned bp3(input int unsigned frac);
    return 32'd5 << frac;
  endfunction

  // Map a magnitude onto its linear segment
  function automatic seg_e seg_of(input int unsigned a, input int unsigned frac);
    if (a < bp1(frac)) return SEG0;
    else if (a < bp2(frac)) return SEG1;
    else if (a < bp3(frac)) return SEG2;
    else return SEG_SAT;
  endfunction

endpackage

// File: rtl/fixed_sigmoid_plan_lane.sv
// One lane of the softplus backward datapath: |x| and segment select,
// PLAN sigmoid, then gradient multiply. Each stage has its own load enable.
// FIXED_SOFTPLUS_BACKWARD_ROUND_EN selects round-half-up instead of floor.
module fixed_sigmoid_plan_lane
  import fixed_softplus_backward_pkg::*;
#(
  parameter int unsigned WL   = 16,
  parameter int unsigned FRAC = 8,
  parameter int unsigned GW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en1_i,
  input  logic          en2_i,
  input  logic          en3_i,
  input  logic [WL-1:0] x_i,
  input  logic [GW-1:0] grad_i,
  output logic [GW-1:0] grad_o
);

  localparam int unsigned AW = WL + 1;
  localparam int unsigned QW = AW + SIG_FRAC - FRAC;
  localparam int unsigned PW = GW + 17;

  logic [AW-1:0] x_ext;
  logic [AW-1:0] a_d, a_q;
  logic          sign_d, sign_q;
  seg_e          seg_d, seg_q;
  logic [GW-1:0] g1_q;

  logic [QW-1:0] q;
  logic [16:0]   p_d;
  logic [15:0]   s_d, s_q;
  logic [GW-1:0] g2_q;

  logic signed [PW-1:0] g_ext, s_ext, prod, prod_r;
  logic [GW-1:0]        res_d, res_q;

  // Stage 1: sign, magnitude (one extra bit so the most-negative x fits), segment
  always_comb begin
    x_ext  = {x_i[WL-1], x_i};
    sign_d = x_i[WL-1];
    a_d    = sign_d ? AW'(~x_ext + AW'(1)) : x_ext;
    seg_d  = seg_of(32'(a_d), FRAC);
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      sign_q <= 1'b0;
      seg_q  <= SEG0;
      g1_q   <= '0;
    end else if (en1_i) begin
      a_q    <= a_d;
      sign_q <= sign_d;
      seg_q  <= seg_d;
      g1_q   <= grad_i;
    end
  end

  // Stage 2: piecewise-linear sigmoid of |x| in Q1.15, mirrored for negative x
  always_comb begin
    q   = QW'(a_q) << (SIG_FRAC - FRAC);
    p_d = 17'(SIG_ONE);
    case (seg_q)
      SEG0:    p_d = 17'(q >> SH0) + 17'(OFF0);
      SEG1:    p_d = 17'(q >> SH1) + 17'(OFF1);
      SEG2:    p_d = 17'(q >> SH2) + 17'(OFF2);
      default: p_d = 17'(SIG_ONE);
    endcase
    s_d = sign_q ? 16'(17'(SIG_ONE) - p_d) : 16'(p_d);
  end

  // Stage 2 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q  <= '0;
      g2_q <= '0;
    end else if (en2_i) begin
      s_q  <= s_d;
      g2_q <= g1_q;
    end
  end

  // Stage 3: grad * sigmoid, rescaled from Q1.15; s <= 1.0 so no saturation
  always_comb begin
    g_ext = {{17{g2_q[GW-1]}}, g2_q};
    s_ext = {(GW+1)'(0), s_q};
    prod  = g_ext * s_ext;
`ifdef FIXED_SOFTPLUS_BACKWARD_ROUND_EN
    prod_r = prod + PW'(RND_HALF);
`else
    prod_r = prod;
`endif
    res_d = GW'(prod_r >>> SIG_FRAC);
  end

  // Stage 3 registers drive the lane output directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_q <= '0;
    else if (en3_i) res_q <= res_d;
  end

  assign grad_o = res_q;

endmodule

// File: rtl/fixed_softplus_backward.sv
// Softplus backward pass: grad_in = grad_out * sigmoid(x), 3-stage elastic
// pipeline joining the saved-x and upstream-gradient streams.
// Define FIXED_SOFTPLUS_BACKWARD_ROUND_EN for round-half-up output.
module fixed_softplus_backward
  import fixed_softplus_backward_pkg::*;
#(
  parameter int unsigned DATA_IN_0_PRECISION_0      = 16,
  parameter int unsigned DATA_IN_0_PRECISION_1      = 8,
  parameter int unsigned DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int unsigned DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int unsigned GRAD_PRECISION_0           = 16,
  parameter int unsigned GRAD_PRECISION_1           = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  input  logic [GRAD_PRECISION_0-1:0]      grad_out [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  input  logic                             grad_out_valid,
  output logic                             grad_out_ready,
  output logic [GRAD_PRECISION_0-1:0]      grad_in [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
  output logic                             grad_in_valid,
  input  logic                             grad_in_ready
);

  localparam int unsigned N = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;

  // Reject configurations the datapath widths are not sized for
  if (DATA_IN_0_PRECISION_1 < 3 || DATA_IN_0_PRECISION_1 > 15) begin : g_bad_frac
    $error("DATA_IN_0_PRECISION_1 must be in 3..15");
  end
  if (GRAD_PRECISION_1 >= GRAD_PRECISION_0) begin : g_bad_grad_fmt
    $error("GRAD_PRECISION_1 must be below GRAD_PRECISION_0");
  end

  logic v1_q, v2_q, v3_q;
  logic load1, load2, load3;
  logic accept;

  // Elastic load chain and two-stream join; a beat needs both streams present
  always_comb begin
    load3  = !v3_q || grad_in_ready;
    load2  = !v2_q || load3;
    load1  = !v1_q || load2;
    accept = !rst && load1 && data_in_0_valid && grad_out_valid;
  end

  assign data_in_0_ready = accept;
  assign grad_out_ready  = accept;
  assign grad_in_valid   = v3_q;

  // Stage valid flags advance only where the downstream stage can take them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (load1) v1_q <= accept;
      if (load2) v2_q <= v1_q;
      if (load3) v3_q <= v2_q;
    end
  end

  for (genvar l = 0; l < int'(N); l++) begin : g_lane
    fixed_sigmoid_plan_lane #(
      .WL  (DATA_IN_0_PRECISION_0),
      .FRAC(DATA_IN_0_PRECISION_1),
      .GW  (GRAD_PRECISION_0)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en1_i (accept),
      .en2_i (load2),
      .en3_i (load3),
      .x_i   (data_in_0[l]),
      .grad_i(grad_out[l]),
      .grad_o(grad_in[l])
    );
  end

endmodule

// File: tb/tb_fixed_softplus_backward.sv
// Self-checking bench for fixed_softplus_backward (FRAC=8, Q8.8 gradient, 2 lanes).
// Expectations follow FIXED_SOFTPLUS_BACKWARD_ROUND_EN as defined for the build.
module tb_fixed_softplus_backward;

  localparam int WL   = 16;
  localparam int FRAC = 8;
  localparam int GW   = 16;
  localparam int N    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [WL-1:0] din [N];
  logic          dv, gv;
  logic [GW-1:0] gdata [N];
  logic          dr, gr;
  logic [GW-1:0] gin [N];
  logic          giv;
  logic          gir = 1'b1;

  always #5 clk = ~clk;

  fixed_softplus_backward #(
    .DATA_IN_0_PRECISION_0      (WL),
    .DATA_IN_0_PRECISION_1      (FRAC),
    .DATA_IN_0_PARALLELISM_DIM_0(N),
    .DATA_IN_0_PARALLELISM_DIM_1(1),
    .GRAD_PRECISION_0           (GW),
    .GRAD_PRECISION_1           (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_0      (din),
    .data_in_0_valid(dv),
    .data_in_0_ready(dr),
    .grad_out       (gdata),
    .grad_out_valid (gv),
    .grad_out_ready (gr),
    .grad_in        (gin),
    .grad_in_valid  (giv),
    .grad_in_ready  (gir)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: sigmoid(x) in Q1.15 straight from the piecewise-linear definition
  function automatic int sig_ref(input int x);
    int a, q, p, one;
    one = 1 << FRAC;
    a   = (x < 0) ? -x : x;
    q   = a * (32768 / one);
    if (a < one)                p = q / 4 + 16384;
    else if (a < 19 * one / 8)  p = q / 8 + 20480;
    else if (a < 5 * one)       p = q / 32 + 27648;
    else                        p = 32768;
    return (x < 0) ? 32768 - p : p;
  endfunction

  // Reference: grad * sigmoid / 32768, floored (optionally with +0.5 first)
  function automatic int grad_ref(input int x, input int g);
    longint prod, r;
    prod = longint'(g) * longint'(sig_ref(x));
`ifdef FIXED_SOFTPLUS_BACKWARD_ROUND_EN
    prod = prod + 64'sd16384;
`endif
    r = prod - (((prod % 64'sd32768) + 64'sd32768) % 64'sd32768);
    return int'(r / 64'sd32768);
  endfunction

  typedef struct { int v [N]; } beat_t;
  beat_t expq [$];

  int mode     = 0;
  int bp_start = 0;
  int cyc      = 0;
  int pops     = 0;
  int stall_seen = 0;
  bit hold     = 1'b0;
  int held [N];

  always @(posedge clk) cyc <= cyc + 1;

  // Output-side ready pattern: 0 always, 1 random, 2 never, 3 low for cycles 4..8
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       gir = 1'b1;
      1:       gir = ($urandom_range(0, 3) != 0);
      2:       gir = 1'b0;
      default: gir = !(((cyc - bp_start) >= 4) && ((cyc - bp_start) <= 8));
    endcase
  end

  // Scoreboard: occupancy-based ready check, output stability, in-order results
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      hold = 1'b0;
    end else begin
      bit full_stall;
      beat_t b, e;
      full_stall = (expq.size() == 3) && !gir;
      chk("data_in_0_ready", int'(dr), int'(dv && gv && !full_stall));
      chk("grad_out_ready",  int'(gr), int'(dv && gv && !full_stall));
      if (dv && gv && !dr) stall_seen++;
      if (hold) begin
        chk("hold_valid", int'(giv), 1);
        for (int l = 0; l < N; l++) chk("hold_data", int'($signed(gin[l])), held[l]);
      end
      if (giv && gir) begin
        if (expq.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = expq.pop_front();
          for (int l = 0; l < N; l++) chk("grad_in", int'($signed(gin[l])), e.v[l]);
        end
        pops++;
      end
      if (dv && gv && dr && gr) begin
        for (int l = 0; l < N; l++)
          b.v[l] = grad_ref(int'($signed(din[l])), int'($signed(gdata[l])));
        expq.push_back(b);
      end
      hold = giv && !gir;
      for (int l = 0; l < N; l++) held[l] = int'($signed(gin[l]));
    end
  end

  // Offer one beat starting at posedge+1; returns at posedge+1 after it is taken
  task automatic push(input int x0, input int g0, input int x1, input int g1);
    bit done;
    done = 1'b0;
    din[0] = WL'(x0); gdata[0] = GW'(g0);
    din[1] = WL'(x1); gdata[1] = GW'(g1);
    dv = 1'b1; gv = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (dr && gr) done = 1'b1;
    end
    if (!done) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    dv = 1'b0; gv = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && expq.size() != 0; t++) @(negedge clk);
    chk("drain_empty", expq.size(), 0);
    @(posedge clk); #1;
  endtask

  typedef struct { int x; int g; int exp; } vec_t;
  vec_t tv [12];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, j, pb;
    bit seen;

    tv[0]  = '{0,      256,    128};
    tv[1]  = '{384,    512,    416};
    tv[2]  = '{-384,   -512,   -96};
    tv[3]  = '{1536,   -300,   -300};
    tv[4]  = '{-32768, 1000,   0};
`ifdef FIXED_SOFTPLUS_BACKWARD_ROUND_EN
    tv[5]  = '{0,      3,      2};
    tv[6]  = '{0,      -3,     -1};
`else
    tv[5]  = '{0,      3,      1};
    tv[6]  = '{0,      -3,     -2};
`endif
    tv[7]  = '{256,    256,    192};
    tv[8]  = '{608,    1024,   940};
    tv[9]  = '{1280,   -1000,  -1000};
    tv[10] = '{-255,   100,    25};
    tv[11] = '{32767,  -32768, -32768};

    // Reset state, with both input valids high to expose ready gating
    rst = 1'b1; dv = 1'b1; gv = 1'b1;
    for (int l = 0; l < N; l++) begin din[l] = '0; gdata[l] = '0; end
    repeat (2) @(negedge clk);
    chk("reset_valid", int'(giv), 0);
    chk("reset_dready", int'(dr), 0);
    chk("reset_gready", int'(gr), 0);
    for (int l = 0; l < N; l++) chk("reset_grad_in", int'(gin[l]), 0);
    @(posedge clk); #1;
    rst = 1'b0; dv = 1'b0; gv = 1'b0;
    @(posedge clk); #1;

    // Directed vectors on an idle pipe: value and 3-cycle latency
    for (int i = 0; i < 12; i++) begin
      j = (i + 1) % 12;
      push(tv[i].x, tv[i].g, tv[j].x, tv[j].g);
      seen = 1'b0; lat = 0;
      for (int k = 1; k <= 8 && !seen; k++) begin
        @(negedge clk);
        if (giv) begin seen = 1'b1; lat = k; end
      end
      chk("latency", lat, 3);
      chk("vec_lane0", int'($signed(gin[0])), tv[i].exp);
      chk("vec_lane1", int'($signed(gin[1])), tv[j].exp);
      @(posedge clk); #1;
    end
    drain();

    // Join: one stream valid alone is never consumed
    din[0] = 16'd384; din[1] = 16'd384; gdata[0] = 16'd7; gdata[1] = 16'd7;
    dv = 1'b1; gv = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    dv = 1'b0; gv = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    gv = 1'b0;
    chk("join_no_accept", expq.size(), 0);
    repeat (4) @(negedge clk);
    chk("join_no_output", int'(giv), 0);
    @(posedge clk); #1;

    // Backpressure: 10 back-to-back beats, output ready low for cycles 4..8
    pb = pops; stall_seen = 0;
    bp_start = cyc; mode = 3;
    for (int i = 0; i < 10; i++)
      push(int'($urandom_range(0, 3072)) - 1536, int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    drain();
    chk("bp_pops", pops - pb, 10);
    chk("bp_ready_dropped", int'(stall_seen > 0), 1);
    mode = 0;

    // Randomized traffic with input gaps and random output ready
    mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      push(($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3072)) - 1536
                                       : int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end
    mode = 0;
    drain();

    // Reset mid-stream with a full, stalled pipe
    mode = 2;
    repeat (3) push(384, 512, -384, -512);
    @(posedge clk); #2;
    chk("pre_reset_valid", int'(giv), 1);
    dv = 1'b1; gv = 1'b1;
    rst = 1'b1;
    #1;
    chk("async_reset_valid", int'(giv), 0);
    chk("async_reset_dready", int'(dr), 0);
    chk("async_reset_gready", int'(gr), 0);
    for (int l = 0; l < N; l++) chk("async_reset_data", int'(gin[l]), 0);
    @(posedge clk); #1;
    rst = 1'b0; dv = 1'b0; gv = 1'b0; mode = 0;
    repeat (5) begin
      @(negedge clk);
      chk("post_reset_empty", int'(giv), 0);
    end
    @(posedge clk); #1;
    push(tv[1].x, tv[1].g, tv[2].x, tv[2].g);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
